// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : mm:ss BCD countdown timer. Each rising edge of tick_in counts one second.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter bit         AUTO_RELOAD = 1'b0,
    parameter logic [7:0] MAX_MIN     = 8'h99
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick_in,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       done_pulse,
    output logic       load_err
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_PAUSE = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]  r_state;
    logic [7:0]  r_min;
    logic [7:0]  r_sec;
    logic [7:0]  r_rl_min;
    logic [7:0]  r_rl_sec;
    logic        r_tick_d;
    logic        r_done_pulse;
    logic        r_load_err;

    logic [1:0]  w_state_nxt;
    logic [7:0]  w_min_nxt;
    logic [7:0]  w_sec_nxt;
    logic [7:0]  w_rl_min_nxt;
    logic [7:0]  w_rl_sec_nxt;
    logic        w_done_pulse_nxt;
    logic        w_load_err_nxt;
    logic        w_sec_evt;
    logic        w_load_ok;
    logic        w_nonzero;
    logic        w_rl_nonzero;
    logic [15:0] w_dec;

    // Digit-wise BCD decrement of {min, sec}; seconds borrow wraps 00 -> 59.
    function automatic logic [15:0] f_bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else if (v[7:4] != 4'd0) begin
            r[7:4] = v[7:4] - 4'd1;
            r[3:0] = 4'd9;
        end else begin
            r[7:0] = 8'h59;
            if (v[11:8] != 4'd0) begin
                r[11:8] = v[11:8] - 4'd1;
            end else begin
                r[15:12] = v[15:12] - 4'd1;
                r[11:8]  = 4'd9;
            end
        end
        return r;
    endfunction

    assign w_sec_evt    = tick_in & ~r_tick_d;
    assign w_nonzero    = ({r_min, r_sec} != 16'h0000);
    assign w_rl_nonzero = ({r_rl_min, r_rl_sec} != 16'h0000);
    assign w_dec        = f_bcd_dec({r_min, r_sec});
    assign w_load_ok    = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                          (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9) &&
                          (load_min <= MAX_MIN);

    always_comb begin
        w_state_nxt      = r_state;
        w_min_nxt        = r_min;
        w_sec_nxt        = r_sec;
        w_rl_min_nxt     = r_rl_min;
        w_rl_sec_nxt     = r_rl_sec;
        w_done_pulse_nxt = 1'b0;
        w_load_err_nxt   = 1'b0;
        // A load owns the cycle: a rejected one leaves count and state untouched.
        if (load) begin
            if (w_load_ok) begin
                w_min_nxt    = load_min;
                w_sec_nxt    = load_sec;
                w_rl_min_nxt = load_min;
                w_rl_sec_nxt = load_sec;
                w_state_nxt  = c_ST_IDLE;
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start && w_nonzero) begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (w_sec_evt) begin
                        {w_min_nxt, w_sec_nxt} = w_dec;
                        if (w_dec == 16'h0000) begin
                            w_done_pulse_nxt = 1'b1;
                            if (AUTO_RELOAD && w_rl_nonzero) begin
                                w_min_nxt = r_rl_min;
                                w_sec_nxt = r_rl_sec;
                                if (pause) begin
                                    w_state_nxt = c_ST_PAUSE;
                                end
                            end else begin
                                w_state_nxt = c_ST_DONE;
                            end
                        end else if (pause) begin
                            w_state_nxt = c_ST_PAUSE;
                        end
                    end else if (pause) begin
                        w_state_nxt = c_ST_PAUSE;
                    end
                end
                c_ST_PAUSE: begin
                    if (start) begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
                c_ST_DONE: begin
                    if (start) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= c_ST_IDLE;
            r_min        <= 8'h00;
            r_sec        <= 8'h00;
            r_rl_min     <= 8'h00;
            r_rl_sec     <= 8'h00;
            r_tick_d     <= 1'b1;
            r_done_pulse <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_min        <= w_min_nxt;
            r_sec        <= w_sec_nxt;
            r_rl_min     <= w_rl_min_nxt;
            r_rl_sec     <= w_rl_sec_nxt;
            r_tick_d     <= tick_in;
            r_done_pulse <= w_done_pulse_nxt;
            r_load_err   <= w_load_err_nxt;
        end
    end

    assign min_bcd    = r_min;
    assign sec_bcd    = r_sec;
    assign running    = (r_state == c_ST_RUN);
    assign done       = (r_state == c_ST_DONE);
    assign done_pulse = r_done_pulse;
    assign load_err   = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Scoreboard bench for countdown_timer; seconds-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    typedef struct packed {
        logic [7:0] mn;
        logic [7:0] sc;
        logic       run;
        logic       dn;
        logic       dp;
        logic       le;
    } exp_t;

    localparam int c_M_IDLE  = 0;
    localparam int c_M_RUN   = 1;
    localparam int c_M_PAUSE = 2;
    localparam int c_M_DONE  = 3;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       tick_in = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_min = 8'h00;
    logic [7:0] load_sec = 8'h00;

    logic [7:0] min0, sec0, min1, sec1;
    logic       run0, done0, dp0, le0, run1, done1, dp1, le1;

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    // Reference model state: count and reload value held as plain seconds.
    int   m_cnt [2];
    int   m_rl  [2];
    int   m_st  [2];
    bit   m_tickd [2];
    bit   m_ar  [2] = '{1'b0, 1'b1};
    int   m_max [2] = '{99, 59};
    logic cur_tick = 1'b0;

    always #5 clk = ~clk;

    countdown_timer #(.AUTO_RELOAD(1'b0), .MAX_MIN(8'h99)) u_dut0 (
        .clk(clk), .clr(clr), .tick_in(tick_in), .start(start), .pause(pause),
        .load(load), .load_min(load_min), .load_sec(load_sec),
        .min_bcd(min0), .sec_bcd(sec0), .running(run0), .done(done0),
        .done_pulse(dp0), .load_err(le0)
    );

    countdown_timer #(.AUTO_RELOAD(1'b1), .MAX_MIN(8'h59)) u_dut1 (
        .clk(clk), .clr(clr), .tick_in(tick_in), .start(start), .pause(pause),
        .load(load), .load_min(load_min), .load_sec(load_sec),
        .min_bcd(min1), .sec_bcd(sec1), .running(run1), .done(done1),
        .done_pulse(dp1), .load_err(le1)
    );

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic model_step(input int i, input logic c, input logic t, input logic s,
                              input logic p, input logic l, input logic [7:0] lm,
                              input logic [7:0] ls, output exp_t e);
        bit evt;
        bit dp;
        bit le;
        bit ok;
        dp = 1'b0;
        le = 1'b0;
        if (c) begin
            m_st[i]    = c_M_IDLE;
            m_cnt[i]   = 0;
            m_rl[i]    = 0;
            m_tickd[i] = 1'b1;
        end else begin
            evt        = t && !m_tickd[i];
            m_tickd[i] = t;
            if (l) begin
                ok = (lm[7:4] <= 9) && (lm[3:0] <= 9) && (ls[7:4] <= 5) && (ls[3:0] <= 9) &&
                     (bcd2int(lm) <= m_max[i]);
                if (ok) begin
                    m_cnt[i] = bcd2int(lm) * 60 + bcd2int(ls);
                    m_rl[i]  = m_cnt[i];
                    m_st[i]  = c_M_IDLE;
                end else begin
                    le = 1'b1;
                end
            end else if (m_st[i] == c_M_IDLE) begin
                if (s && m_cnt[i] != 0) m_st[i] = c_M_RUN;
            end else if (m_st[i] == c_M_RUN) begin
                if (evt) m_cnt[i] = m_cnt[i] - 1;
                if (evt && m_cnt[i] == 0) begin
                    dp = 1'b1;
                    if (m_ar[i] && m_rl[i] != 0) begin
                        m_cnt[i] = m_rl[i];
                        if (p) m_st[i] = c_M_PAUSE;
                    end else begin
                        m_st[i] = c_M_DONE;
                    end
                end else if (p) begin
                    m_st[i] = c_M_PAUSE;
                end
            end else if (m_st[i] == c_M_PAUSE) begin
                if (s) m_st[i] = c_M_RUN;
            end else begin
                if (s) m_st[i] = c_M_IDLE;
            end
        end
        e.mn  = int2bcd(m_cnt[i] / 60);
        e.sc  = int2bcd(m_cnt[i] % 60);
        e.run = (m_st[i] == c_M_RUN);
        e.dn  = (m_st[i] == c_M_DONE);
        e.dp  = dp;
        e.le  = le;
    endtask

    task automatic drive(input logic c, input logic t, input logic s, input logic p,
                         input logic l, input logic [7:0] lm, input logic [7:0] ls);
        exp_t e;
        @(negedge clk);
        #2;
        clr = c; tick_in = t; start = s; pause = p; load = l; load_min = lm; load_sec = ls;
        cur_tick = t;
        model_step(0, c, t, s, p, l, lm, ls, e);
        q0.push_back(e);
        model_step(1, c, t, s, p, l, lm, ls, e);
        q1.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, cur_tick, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_load(input logic [7:0] lm, input logic [7:0] ls);
        drive(1'b0, cur_tick, 1'b0, 1'b0, 1'b1, lm, ls);
    endtask

    task automatic do_start();
        drive(1'b0, cur_tick, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic sec_edges(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        end
    endtask

    task automatic compare(input int i, input exp_t e, input exp_t a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL out_inst%0d t=%0t got min=%h sec=%h run=%b done=%b dp=%b lerr=%b exp min=%h sec=%h run=%b done=%b dp=%b lerr=%b",
                     i, $time, a.mn, a.sc, a.run, a.dn, a.dp, a.le, e.mn, e.sc, e.run, e.dn, e.dp, e.le);
        end
    endtask

    // Monitor: every clock the outputs are a fresh response; match it against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            compare(0, e, {min0, sec0, run0, done0, dp0, le0});
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            compare(1, e, {min1, sec1, run1, done1, dp1, le1});
        end
    end

    initial begin
        logic       c, t, s, p, l;
        logic [7:0] lm, ls;
        // Reset with tick held high, then release: no second event may appear.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        idle(3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        // Minute borrow.
        do_load(8'h01, 8'h00); do_start(); sec_edges(10);
        // Expiry, edges after expiry, start from DONE.
        do_load(8'h00, 8'h02); do_start(); sec_edges(4); do_start(); idle(2);
        // Pause coinciding with a second edge.
        do_load(8'h00, 8'h10); do_start();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        idle(2); sec_edges(3); do_start(); sec_edges(1);
        // Load checks: bad seconds, load during RUN, start from 00:00, minute limit.
        do_load(8'h00, 8'h60); idle(1);
        do_load(8'h00, 8'h05); do_start(); sec_edges(1);
        do_load(8'h12, 8'h34); idle(1);
        do_load(8'h00, 8'h00); do_start(); idle(1);
        do_load(8'h75, 8'h00); do_load(8'h1A, 8'h00); do_load(8'h00, 8'h0F); idle(1);
        // Auto-reload sequence.
        do_load(8'h00, 8'h02); do_start(); sec_edges(5);
        // Mid-run reset.
        do_load(8'h00, 8'h30); do_start(); sec_edges(2);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00); idle(2);
        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            t = cur_tick;
            if ($urandom_range(0, 3) == 0) t = ~cur_tick;
            c = ($urandom_range(0, 799) == 0);
            s = ($urandom_range(0, 11) == 0);
            p = ($urandom_range(0, 24) == 0);
            l = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) begin
                lm = 8'($urandom);
                ls = 8'($urandom);
            end else begin
                lm = int2bcd($urandom_range(0, 2));
                ls = int2bcd($urandom_range(0, 20));
            end
            drive(c, t, s, p, l, lm, ls);
        end
        for (int k = 0; k < 10 && (q0.size() > 0 || q1.size() > 0); k++) @(negedge clk);
        #1;
        if (q0.size() > 0 || q1.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending required 0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
